// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory opcode values and LSU state encoding.
package mips_pkg;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WB     = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
// Store side: decodes the incoming opcode into mem/store/misaligned flags,
//   byte enables and lane-replicated write data.
// Load side: extracts and zero-extends the addressed lane of a read word.
// Ports:
//   st_opcode, st_addr_lo, st_data -> is_mem, is_store, misaligned, be, wdata
//   ld_opcode, ld_addr_lo, ld_word -> ld_data
module lsu_lane_align
  import mips_pkg::*;
(
  input  logic [5:0]  st_opcode,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic        is_mem,
  output logic        is_store,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [5:0]  ld_opcode,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  // Store-side decode, enables and replicated data
  always_comb begin
    is_mem     = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    be         = 4'b1111;
    wdata      = 32'h0000_0000;
    case (st_opcode)
      OP_LW, OP_LL: begin
        is_mem     = 1'b1;
        misaligned = (st_addr_lo != 2'b00);
      end
      OP_LHU: begin
        is_mem     = 1'b1;
        misaligned = st_addr_lo[0];
      end
      OP_LBU: begin
        is_mem = 1'b1;
      end
      OP_SW: begin
        is_mem     = 1'b1;
        is_store   = 1'b1;
        misaligned = (st_addr_lo != 2'b00);
        wdata      = st_data;
      end
      OP_SH: begin
        is_mem     = 1'b1;
        is_store   = 1'b1;
        misaligned = st_addr_lo[0];
        be         = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{st_data[15:0]}};
      end
      OP_SB: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        be       = 4'b0001 << st_addr_lo;
        wdata    = {4{st_data[7:0]}};
      end
      default: begin
        is_mem = 1'b0;
      end
    endcase
  end

  // Load-side lane extract with zero extension
  always_comb begin
    ld_data = ld_word;
    case (ld_opcode)
      OP_LHU: begin
        if (ld_addr_lo[1]) begin
          ld_data = {16'h0000, ld_word[31:16]};
        end else begin
          ld_data = {16'h0000, ld_word[15:0]};
        end
      end
      OP_LBU: begin
        case (ld_addr_lo)
          2'd0:    ld_data = {24'h000000, ld_word[7:0]};
          2'd1:    ld_data = {24'h000000, ld_word[15:8]};
          2'd2:    ld_data = {24'h000000, ld_word[23:16]};
          default: ld_data = {24'h000000, ld_word[31:24]};
        endcase
      end
      default: begin
        ld_data = ld_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM stage of the MIPS datapath. Accepts one packet at a time, runs
// loads/stores over a req/ack memory port, and emits a registered
// writeback packet. Non-memory results pass straight to writeback.
// Ports:
//   upstream : in_valid/in_ready, in_opcode, in_alu_res, in_rt, in_wreg, in_wen
//   memory   : mem_req, mem_we, mem_addr, mem_be, mem_wdata, mem_rdata, mem_ack
//   writeback: wb_valid, wb_en, wb_reg, wb_data
//   status   : misalign_err, bus_err (pulses), link_valid, link_addr (LL reservation)
module load_store_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [31:0] in_alu_res,
  input  logic [31:0] in_rt,
  input  logic [4:0]  in_wreg,
  input  logic        in_wen,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        link_valid,
  output logic [29:0] link_addr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_t    state_r;
  logic [5:0]    op_r;
  logic [1:0]    addr_lo_r;
  logic [4:0]    wreg_r;
  logic          wen_r;
  logic [CW-1:0] cnt_r;

  logic          is_mem_s;
  logic          is_store_s;
  logic          misaligned_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  logic [31:0]   ld_data_s;

  lsu_lane_align u_align (
    .st_opcode  (in_opcode),
    .st_addr_lo (in_alu_res[1:0]),
    .st_data    (in_rt),
    .is_mem     (is_mem_s),
    .is_store   (is_store_s),
    .misaligned (misaligned_s),
    .be         (be_s),
    .wdata      (wdata_s),
    .ld_opcode  (op_r),
    .ld_addr_lo (addr_lo_r),
    .ld_word    (mem_rdata),
    .ld_data    (ld_data_s)
  );

  // Main FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      op_r         <= 6'd0;
      addr_lo_r    <= 2'd0;
      wreg_r       <= 5'd0;
      wen_r        <= 1'b0;
      cnt_r        <= '0;
      in_ready     <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0000_0000;
      mem_be       <= 4'b0000;
      mem_wdata    <= 32'h0000_0000;
      wb_valid     <= 1'b0;
      wb_en        <= 1'b0;
      wb_reg       <= 5'd0;
      wb_data      <= 32'h0000_0000;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      link_valid   <= 1'b0;
      link_addr    <= 30'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            op_r      <= in_opcode;
            addr_lo_r <= in_alu_res[1:0];
            wreg_r    <= in_wreg;
            wen_r     <= in_wen & ~is_store_s;
            in_ready  <= 1'b0;
            if (!is_mem_s) begin
              state_r  <= ST_WB;
              wb_valid <= 1'b1;
              wb_en    <= in_wen;
              wb_reg   <= in_wreg;
              wb_data  <= in_alu_res;
            end else if (misaligned_s) begin
              // Faulting access never reaches the memory port
              state_r      <= ST_WB;
              wb_valid     <= 1'b1;
              wb_en        <= 1'b0;
              wb_reg       <= in_wreg;
              wb_data      <= 32'h0000_0000;
              misalign_err <= 1'b1;
            end else begin
              state_r   <= ST_ACCESS;
              cnt_r     <= CW'(1);
              mem_req   <= 1'b1;
              mem_we    <= is_store_s;
              mem_addr  <= {in_alu_res[31:2], 2'b00};
              mem_be    <= be_s;
              mem_wdata <= wdata_s;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            state_r  <= ST_WB;
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_en    <= wen_r;
            wb_reg   <= wreg_r;
            wb_data  <= mem_we ? 32'h0000_0000 : ld_data_s;
            if (op_r == OP_LL) begin
              link_valid <= 1'b1;
              link_addr  <= mem_addr[31:2];
            end else if (mem_we && (link_addr == mem_addr[31:2])) begin
              link_valid <= 1'b0;
            end else begin
              link_valid <= link_valid;
            end
          end else if (cnt_r == CW'(TIMEOUT)) begin
            state_r  <= ST_WB;
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_en    <= 1'b0;
            wb_reg   <= wreg_r;
            wb_data  <= 32'h0000_0000;
            bus_err  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_WB: begin
          state_r      <= ST_IDLE;
          in_ready     <= 1'b1;
          wb_valid     <= 1'b0;
          misalign_err <= 1'b0;
          bus_err      <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          in_ready <= 1'b1;
          mem_req  <= 1'b0;
          wb_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected writeback packets and
// memory requests are queued when stimulus is driven and compared when
// the DUT produces them.
module tb_load_store_unit;
  import mips_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_opcode = 6'd0;
  logic [31:0] in_alu_res = 32'd0;
  logic [31:0] in_rt = 32'd0;
  logic [4:0]  in_wreg = 5'd0;
  logic        in_wen = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        wb_valid, wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        misalign_err, bus_err, link_valid;
  logic [29:0] link_addr;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_alu_res(in_alu_res), .in_rt(in_rt),
    .in_wreg(in_wreg), .in_wen(in_wen), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err),
    .link_valid(link_valid), .link_addr(link_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [4:0]  rg;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic        bus;
    logic [31:0] cyc;
  } wb_exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        chk_wd;
  } mem_exp_t;

  wb_exp_t  wb_q[$];
  mem_exp_t mem_q[$];

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] cyc = 32'd0;
  int ack_at_g = 0;
  logic [31:0] rdata_g = 32'd0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory responder: acks on access cycle ack_at_g (0 = never)
  initial begin
    int cnt;
    mem_exp_t m;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (reset || !mem_req) begin
        cnt = 0;
        mem_ack = 1'b0;
      end else begin
        cnt++;
        if (cnt == 1) begin
          if (mem_q.size() == 0) begin
            chk("mem_req_unexp", {31'd0, mem_req}, 32'd0);
          end else begin
            m = mem_q.pop_front();
            chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
            chk("mem_addr", mem_addr, m.addr);
            chk("mem_be", {28'd0, mem_be}, {28'd0, m.be});
            if (m.chk_wd) chk("mem_wdata", mem_wdata, m.wd);
          end
        end
        if (cnt == ack_at_g) begin
          mem_ack = 1'b1;
          mem_rdata = rdata_g;
        end else begin
          mem_ack = 1'b0;
        end
      end
    end
  end

  // Writeback monitor
  always @(negedge clk) begin
    wb_exp_t e;
    if (!reset && wb_valid) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexp", {31'd0, wb_valid}, 32'd0);
      end else begin
        e = wb_q.pop_front();
        chk("wb_en", {31'd0, wb_en}, {31'd0, e.en});
        chk("wb_reg", {27'd0, wb_reg}, {27'd0, e.rg});
        if (e.chk_data) chk("wb_data", wb_data, e.data);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
        chk("bus_err", {31'd0, bus_err}, {31'd0, e.bus});
        chk("wb_cycle", cyc, e.cyc);
      end
    end else if (!reset && (misalign_err || bus_err)) begin
      chk("err_without_wb", {30'd0, misalign_err, bus_err}, 32'd0);
    end
  end

  task automatic send(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] rt,
                      input logic [4:0] wreg, input logic wen, input int ack,
                      input logic [31:0] rdata, input logic goes_mem,
                      input logic [3:0] be, input logic [31:0] wd, input logic chk_wd,
                      input logic exp_en, input logic [31:0] exp_data, input logic chk_data,
                      input logic mis, input logic bus, input logic push_wb);
    int t;
    int delta;
    mem_exp_t m;
    wb_exp_t e;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    ack_at_g = ack;
    rdata_g = rdata;
    if (!goes_mem) delta = 0;
    else if (ack == 0) delta = TO;
    else delta = ack;
    if (goes_mem) begin
      m = '{we: (op == OP_SW || op == OP_SH || op == OP_SB), addr: {alu[31:2], 2'b00},
            be: be, wd: wd, chk_wd: chk_wd};
      mem_q.push_back(m);
    end
    if (push_wb) begin
      e = '{en: exp_en, rg: wreg, data: exp_data, chk_data: chk_data,
            mis: mis, bus: bus, cyc: cyc + 32'd1 + 32'(delta)};
      wb_q.push_back(e);
    end
    in_opcode = op; in_alu_res = alu; in_rt = rt; in_wreg = wreg; in_wen = wen;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((wb_q.size() != 0 || mem_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_wb", 32'(wb_q.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_link_valid", {31'd0, link_valid}, 32'd0);
    chk("rst_errs", {30'd0, misalign_err, bus_err}, 32'd0);
    reset = 1'b0;

    //   op      alu           rt            wreg  wen  ack rdata         mem be       wdata         cwd en  data          cd mis bus push
    send(OP_SW,  32'h100, 32'hDEADBEEF, 5'd1, 1'b1, 2, 32'h0,        1'b1, 4'b1111, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(OP_SB,  32'h103, 32'h000000AB, 5'd2, 1'b0, 1, 32'h0,        1'b1, 4'b1000, 32'hABABABAB, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(OP_LBU, 32'h103, 32'h0,        5'd7, 1'b1, 1, 32'hAB112233, 1'b1, 4'b1111, 32'h0,        1'b0, 1'b1, 32'h000000AB, 1'b1, 1'b0, 1'b0, 1'b1);
    send(OP_LBU, 32'h101, 32'h0,        5'd8, 1'b1, 1, 32'hAB112233, 1'b1, 4'b1111, 32'h0,        1'b0, 1'b1, 32'h00000022, 1'b1, 1'b0, 1'b0, 1'b1);
    send(OP_LHU, 32'h102, 32'h0,        5'd9, 1'b1, 3, 32'hBEEF1234, 1'b1, 4'b1111, 32'h0,        1'b0, 1'b1, 32'h0000BEEF, 1'b1, 1'b0, 1'b0, 1'b1);
    send(OP_LHU, 32'h100, 32'h0,        5'd9, 1'b1, 1, 32'hBEEF1234, 1'b1, 4'b1111, 32'h0,        1'b0, 1'b1, 32'h00001234, 1'b1, 1'b0, 1'b0, 1'b1);
    send(OP_LHU, 32'h101, 32'h0,        5'd3, 1'b1, 1, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    send(6'h00,  32'h1234, 32'h0,       5'd5, 1'b1, 0, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 32'h00001234, 1'b1, 1'b0, 1'b0, 1'b1);
    send(6'h08,  32'hFFFF0000, 32'h0,   5'd6, 1'b0, 0, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 32'hFFFF0000, 1'b1, 1'b0, 1'b0, 1'b1);
    send(OP_SH,  32'h102, 32'h1234ABCD, 5'd4, 1'b1, 1, 32'h0,        1'b1, 4'b1100, 32'hABCDABCD, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(OP_SH,  32'h100, 32'h1234ABCD, 5'd4, 1'b1, 1, 32'h0,        1'b1, 4'b0011, 32'hABCDABCD, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(OP_LW,  32'h106, 32'h0,        5'd10, 1'b1, 1, 32'h0,       1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    send(OP_LW,  32'h108, 32'h0,        5'd11, 1'b1, 1, 32'hCAFEF00D, 1'b1, 4'b1111, 32'h0,       1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    // Ack withheld: timeout then back to ready
    send(OP_LW,  32'h10C, 32'h0,        5'd12, 1'b1, 0, 32'h0,       1'b1, 4'b1111, 32'h0,        1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    chk("ready_after_timeout", {31'd0, in_ready}, 32'd1);

    // LL reservation, unrelated store, then same-word store
    send(OP_LL,  32'h200, 32'h0,        5'd13, 1'b1, 1, 32'h00000055, 1'b1, 4'b1111, 32'h0,       1'b0, 1'b1, 32'h00000055, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();
    chk("link_valid_set", {31'd0, link_valid}, 32'd1);
    chk("link_addr", {2'd0, link_addr}, 32'h80);
    send(OP_SW,  32'h204, 32'h11111111, 5'd0, 1'b0, 1, 32'h0,       1'b1, 4'b1111, 32'h11111111, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    chk("link_kept", {31'd0, link_valid}, 32'd1);
    send(OP_SW,  32'h200, 32'h22222222, 5'd0, 1'b0, 2, 32'h0,       1'b1, 4'b1111, 32'h22222222, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    chk("link_cleared", {31'd0, link_valid}, 32'd0);

    // Reset in the middle of an access
    send(OP_LL,  32'h300, 32'h0,        5'd14, 1'b1, 1, 32'h00000077, 1'b1, 4'b1111, 32'h0,       1'b0, 1'b1, 32'h00000077, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();
    chk("link_valid_ll2", {31'd0, link_valid}, 32'd1);
    send(OP_LW,  32'h304, 32'h0,        5'd15, 1'b1, 0, 32'h0,       1'b1, 4'b1111, 32'h0,        1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("mem_req_before_rst", {31'd0, mem_req}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mem_req_async_rst", {31'd0, mem_req}, 32'd0);
    chk("link_async_rst", {31'd0, link_valid}, 32'd0);
    chk("in_ready_async_rst", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Recovery after reset
    send(6'h00,  32'h00ABCDEF, 32'h0,   5'd17, 1'b1, 0, 32'h0,       1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 32'h00ABCDEF, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
